// File: rtl/coeff_sched.sv
// coeff_sched: walks a frame's tile descriptors and issues each tile's Gaussians with the tile origin attached.
// Latency: out_valid rises one cycle after a Gaussian handshake; sustains one Gaussian per cycle.
// Backpressure: g_ready drops while the output register holds an unaccepted word; optional counters under COEFF_SCHED_STATS_EN.
module coeff_sched #(
    parameter int TILE_SIZE  = 16,
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [CNT_WIDTH-1:0]         num_tiles,
    input  logic                         abort,
    output logic                         busy,
    output logic                         done,
    input  logic                         tile_valid,
    output logic                         tile_ready,
    input  logic [CNT_WIDTH-1:0]         tile_x,
    input  logic [CNT_WIDTH-1:0]         tile_y,
    input  logic [CNT_WIDTH-1:0]         tile_gcount,
    output logic                         tile_skip,
    input  logic                         g_valid,
    output logic                         g_ready,
    input  logic signed [DATA_WIDTH-1:0] g_a,
    input  logic signed [DATA_WIDTH-1:0] g_b,
    input  logic signed [DATA_WIDTH-1:0] g_c,
    input  logic signed [DATA_WIDTH-1:0] g_mu_x,
    input  logic signed [DATA_WIDTH-1:0] g_mu_y,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_a,
    output logic signed [DATA_WIDTH-1:0] out_b,
    output logic signed [DATA_WIDTH-1:0] out_c,
    output logic signed [DATA_WIDTH-1:0] out_mu_x,
    output logic signed [DATA_WIDTH-1:0] out_mu_y,
    output logic signed [DATA_WIDTH-1:0] out_x,
    output logic signed [DATA_WIDTH-1:0] out_y,
    output logic                         out_end_of_tile
`ifdef COEFF_SCHED_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]         stat_issued,
    output logic [CNT_WIDTH-1:0]         stat_stall
`endif
);

    // Tile index to fixed-point pixel origin is a pure left shift; wide
    // intermediate so the truncation to DATA_WIDTH is explicit.
    localparam int SHIFT = $clog2(TILE_SIZE) + FRAC_BITS;
    localparam int WW    = DATA_WIDTH + CNT_WIDTH + SHIFT;

    typedef enum logic [1:0] {S_IDLE, S_LOAD_TILE, S_ISSUE, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    tiles_left_q, tiles_left_d;
    logic [CNT_WIDTH-1:0]    gauss_left_q, gauss_left_d;
    logic [DATA_WIDTH-1:0]   origin_x_q, origin_x_d;
    logic [DATA_WIDTH-1:0]   origin_y_q, origin_y_d;
    logic                    tile_skip_q, tile_skip_d;
    logic                    out_valid_q;
    logic [DATA_WIDTH-1:0]   out_a_q, out_b_q, out_c_q, out_mu_x_q, out_mu_y_q;
    logic [DATA_WIDTH-1:0]   out_x_q, out_y_q;
    logic                    out_eot_q;

    logic [WW-1:0]           ox_wide, oy_wide;
    logic                    tile_hs, g_hs, out_hs, done_fire;
    logic                    last_tile, last_gauss;

    function automatic logic [CNT_WIDTH-1:0] sat_dec(input logic [CNT_WIDTH-1:0] v);
        return (v == '0) ? '0 : v - CNT_WIDTH'(1);
    endfunction

    assign ox_wide    = WW'(tile_x) << SHIFT;
    assign oy_wide    = WW'(tile_y) << SHIFT;

    assign tile_ready = (state_q == S_LOAD_TILE);
    assign g_ready    = (state_q == S_ISSUE) && (!out_valid_q || out_ready);
    assign busy       = (state_q != S_IDLE);
    // abort wins over every handshake, so a handshake seen alongside it is dropped
    assign tile_hs    = tile_ready && tile_valid && !abort;
    assign g_hs       = g_ready && g_valid && !abort;
    assign out_hs     = out_valid_q && out_ready;
    assign last_tile  = (tiles_left_q <= CNT_WIDTH'(1));
    assign last_gauss = (gauss_left_q == CNT_WIDTH'(1));
    // DONE completes once the final word has left (or is leaving this cycle)
    assign done_fire  = (state_q == S_DONE) && (!out_valid_q || out_ready);
    assign done       = done_fire && !abort;
    assign tile_skip  = tile_skip_q;

    // Next-state, counter and origin bookkeeping
    always_comb begin
        state_d      = state_q;
        tiles_left_d = tiles_left_q;
        gauss_left_d = gauss_left_q;
        origin_x_d   = origin_x_q;
        origin_y_d   = origin_y_q;
        tile_skip_d  = 1'b0;
        if (abort) begin
            state_d      = S_IDLE;
            tiles_left_d = '0;
            gauss_left_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        tiles_left_d = num_tiles;
                        state_d      = (num_tiles == '0) ? S_DONE : S_LOAD_TILE;
                    end
                end
                S_LOAD_TILE: begin
                    if (tile_hs) begin
                        origin_x_d   = ox_wide[DATA_WIDTH-1:0];
                        origin_y_d   = oy_wide[DATA_WIDTH-1:0];
                        gauss_left_d = tile_gcount;
                        if (tile_gcount == '0) begin
                            tile_skip_d  = 1'b1;
                            tiles_left_d = sat_dec(tiles_left_q);
                            state_d      = last_tile ? S_DONE : S_LOAD_TILE;
                        end else begin
                            state_d = S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (g_hs) begin
                        gauss_left_d = sat_dec(gauss_left_q);
                        if (last_gauss) begin
                            tiles_left_d = sat_dec(tiles_left_q);
                            state_d      = last_tile ? S_DONE : S_LOAD_TILE;
                        end
                    end
                end
                S_DONE: begin
                    if (done_fire) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Controller state and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            tiles_left_q <= '0;
            gauss_left_q <= '0;
            origin_x_q   <= '0;
            origin_y_q   <= '0;
            tile_skip_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tiles_left_q <= tiles_left_d;
            gauss_left_q <= gauss_left_d;
            origin_x_q   <= origin_x_d;
            origin_y_q   <= origin_y_d;
            tile_skip_q  <= tile_skip_d;
        end
    end

    // Output register: loads on a Gaussian handshake, holds while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_c_q     <= '0;
            out_mu_x_q  <= '0;
            out_mu_y_q  <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_eot_q   <= 1'b0;
        end else if (abort) begin
            out_valid_q <= 1'b0;
        end else if (g_hs) begin
            out_valid_q <= 1'b1;
            out_a_q     <= g_a;
            out_b_q     <= g_b;
            out_c_q     <= g_c;
            out_mu_x_q  <= g_mu_x;
            out_mu_y_q  <= g_mu_y;
            out_x_q     <= origin_x_q;
            out_y_q     <= origin_y_q;
            out_eot_q   <= last_gauss;
        end else if (out_hs) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_a           = out_a_q;
    assign out_b           = out_b_q;
    assign out_c           = out_c_q;
    assign out_mu_x        = out_mu_x_q;
    assign out_mu_y        = out_mu_y_q;
    assign out_x           = out_x_q;
    assign out_y           = out_y_q;
    assign out_end_of_tile = out_eot_q;

`ifdef COEFF_SCHED_STATS_EN
    logic [CNT_WIDTH-1:0] stat_issued_q, stat_stall_q;

    // Saturating issue/stall counters, restarted with each accepted frame
    always_ff @(posedge clk) begin
        if (rst || ((state_q == S_IDLE) && start && !abort)) begin
            stat_issued_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            if (out_hs && (stat_issued_q != '1))
                stat_issued_q <= stat_issued_q + CNT_WIDTH'(1);
            if (out_valid_q && !out_ready && (stat_stall_q != '1))
                stat_stall_q <= stat_stall_q + CNT_WIDTH'(1);
        end
    end

    assign stat_issued = stat_issued_q;
    assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_coeff_sched.sv
// tb_coeff_sched: randomized and directed frames against a queue-based model of the issued stream.
// Latency: model is order-based; outputs are matched at each output handshake.
// Backpressure: out_ready driven always-high, random, or held low per test.
module tb_coeff_sched;
    localparam int TS = 16;
    localparam int FB = 16;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [15:0] num_tiles;
    logic        busy, done;
    logic        tile_valid, tile_ready, tile_skip;
    logic [15:0] tile_x, tile_y, tile_gcount;
    logic        g_valid, g_ready;
    logic [31:0] g_a, g_b, g_c, g_mu_x, g_mu_y;
    logic        out_valid, out_ready;
    logic [31:0] out_a, out_b, out_c, out_mu_x, out_mu_y, out_x, out_y;
    logic        out_end_of_tile;
`ifdef COEFF_SCHED_STATS_EN
    logic [15:0] stat_issued, stat_stall;
`endif

    always #5 clk = ~clk;

    coeff_sched dut (
        .clk(clk), .rst(rst), .start(start), .num_tiles(num_tiles), .abort(abort),
        .busy(busy), .done(done),
        .tile_valid(tile_valid), .tile_ready(tile_ready),
        .tile_x(tile_x), .tile_y(tile_y), .tile_gcount(tile_gcount), .tile_skip(tile_skip),
        .g_valid(g_valid), .g_ready(g_ready),
        .g_a(g_a), .g_b(g_b), .g_c(g_c), .g_mu_x(g_mu_x), .g_mu_y(g_mu_y),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_mu_x(out_mu_x), .out_mu_y(out_mu_y),
        .out_x(out_x), .out_y(out_y), .out_end_of_tile(out_end_of_tile)
`ifdef COEFF_SCHED_STATS_EN
        , .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
    );

    typedef struct packed {
        logic [31:0] a, b, c, mx, my, x, y;
        logic        eot;
    } exp_t;

    int          checks = 0, errors = 0;
    exp_t        exp_q[$];
    logic [31:0] cap_x[$], cap_y[$];
    logic        cap_eot[$];
    logic [15:0] ft_x[$], ft_y[$], ft_g[$];
    int          done_cnt, skip_cnt, tr_cnt, rdy_mode;
    time         done_t, start_t;
    bit          kill;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, expv);
        end
    endtask

    // Model: a tile's fixed-point origin is its pixel origin scaled by 2^FB, kept to 32 bits
    function automatic logic [31:0] org(input logic [15:0] v);
        logic [63:0] w;
        w = 64'(v) * TS;
        w = w << FB;
        return w[31:0];
    endfunction

    // out_ready policy: 0 = always ready, 1 = random, 2 = held low
    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(1)) : 1'b0;
        end
    end

    // Compare process: every output handshake must match the model queue head;
    // a stalled word must be unchanged on the next cycle.
    initial begin
        exp_t cur, snap, e;
        logic hold;
        hold = 1'b0;
        snap = '0;
        forever begin
            @(negedge clk);
            #2;
            cur = {out_a, out_b, out_c, out_mu_x, out_mu_y, out_x, out_y, out_end_of_tile};
            if (rst) begin
                hold = 1'b0;
            end else begin
                if (hold) chk("hold_stable", {out_valid, cur}, {1'b1, snap});
                if (done) begin done_cnt++; done_t = $time; end
                if (tile_skip) skip_cnt++;
                if (tile_ready) tr_cnt++;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out", 256'(cur), 256'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_params", {out_a, out_b, out_c, out_mu_x, out_mu_y}, {e.a, e.b, e.c, e.mx, e.my});
                        chk("out_origin", {out_x, out_y}, {e.x, e.y});
                        chk("out_eot", out_end_of_tile, e.eot);
                    end
                    cap_x.push_back(out_x);
                    cap_y.push_back(out_y);
                    cap_eot.push_back(out_end_of_tile);
                end
                hold = out_valid && !out_ready && !abort;
                snap = cur;
            end
        end
    end

    // Called just after a negedge with valid/data already driven
    task automatic wait_hs(input bit is_g, output bit ok);
        int cyc;
        bit fin;
        cyc = 0; ok = 0; fin = 0;
        while (!fin) begin
            #1;
            if (kill) fin = 1;
            else if (is_g ? (g_valid && g_ready) : (tile_valid && tile_ready)) begin
                ok = 1; fin = 1;
            end else if (cyc >= 400) begin
                checks++; errors++;
                $display("FAIL hs_timeout: got no handshake want handshake (is_g=%0d)", is_g);
                fin = 1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (ok) begin @(posedge clk); @(negedge clk); end
    endtask

    // Drives the frame held in ft_* and records the expected output stream
    task automatic drive_frame();
        bit   ok;
        exp_t e;
        start = 1'b1;
        num_tiles = 16'(ft_g.size());
        start_t = $time;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < ft_g.size() && !kill; t++) begin
            tile_valid = 1'b1; tile_x = ft_x[t]; tile_y = ft_y[t]; tile_gcount = ft_g[t];
            wait_hs(0, ok);
            tile_valid = 1'b0;
            for (int gi = 0; ok && gi < int'(ft_g[t]) && !kill; gi++) begin
                if ($urandom_range(3) == 0) begin g_valid = 1'b0; @(negedge clk); end
                g_valid = 1'b1;
                g_a = $urandom; g_b = $urandom; g_c = $urandom; g_mu_x = $urandom; g_mu_y = $urandom;
                e = {g_a, g_b, g_c, g_mu_x, g_mu_y, org(ft_x[t]), org(ft_y[t]), 1'(gi == int'(ft_g[t]) - 1)};
                wait_hs(1, ok);
                if (ok) exp_q.push_back(e);
            end
            g_valid = 1'b0;
        end
        tile_valid = 1'b0;
        g_valid = 1'b0;
    endtask

    task automatic new_frame();
        done_cnt = 0; skip_cnt = 0; tr_cnt = 0; kill = 0;
        cap_x.delete(); cap_y.delete(); cap_eot.delete();
        ft_x.delete(); ft_y.delete(); ft_g.delete();
    endtask

    task automatic add_tile(input logic [15:0] x, input logic [15:0] y, input logic [15:0] g);
        ft_x.push_back(x); ft_y.push_back(y); ft_g.push_back(g);
    endtask

    task automatic finish_frame(input string nm, input int skips, input int outs);
        int cyc;
        cyc = 0;
        while (done_cnt == 0 && cyc < 500) begin @(negedge clk); #3; cyc++; end
        repeat (3) @(negedge clk);
        #3;
        chk({nm, "_done"}, done_cnt, 1);
        chk({nm, "_skips"}, skip_cnt, skips);
        chk({nm, "_outs"}, cap_x.size(), outs);
        chk({nm, "_drained"}, exp_q.size(), 0);
        chk({nm, "_idle"}, busy, 0);
    endtask

    // Holds out_ready low until a word is waiting, then interrupts with abort or rst
    task automatic interrupt_test(input string nm, input bit use_rst);
        int cyc;
        new_frame();
        add_tile(16'd1, 16'd1, 16'd3);
        rdy_mode = 2;
        fork
            drive_frame();
            begin
                cyc = 0;
                do begin @(negedge clk); #2; cyc++; end while (!out_valid && cyc < 100);
                chk({nm, "_valid_before"}, out_valid, 1);
                @(negedge clk);
                kill = 1;
                if (use_rst) rst = 1'b1; else abort = 1'b1;
                @(negedge clk);
                rst = 1'b0; abort = 1'b0;
                #2;
                chk({nm, "_busy"}, busy, 0);
                chk({nm, "_out_valid"}, out_valid, 0);
                chk({nm, "_no_done"}, done_cnt, 0);
                if (use_rst) chk({nm, "_out_x_cleared"}, out_x, 0);
            end
        join
        exp_q.delete();
        rdy_mode = 0;
        // start on the very next cycle must be taken
        new_frame();
        add_tile(16'd4, 16'd4, 16'd1);
        drive_frame();
        finish_frame({nm, "_restart"}, 0, 1);
    endtask

    initial begin
        int n, zeros, outs, cyc;
        rst = 1'b1; start = 1'b0; abort = 1'b0; num_tiles = '0;
        tile_valid = 1'b0; tile_x = '0; tile_y = '0; tile_gcount = '0;
        g_valid = 1'b0; g_a = '0; g_b = '0; g_c = '0; g_mu_x = '0; g_mu_y = '0;
        rdy_mode = 0; kill = 0; done_cnt = 0; skip_cnt = 0; tr_cnt = 0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_ctrl", {busy, done, tile_skip, tile_ready, g_ready, out_valid}, 6'b0);
        chk("rst_data", {out_a, out_b, out_c, out_mu_x, out_mu_y, out_x, out_y, out_end_of_tile}, 225'b0);
        @(negedge clk);
        rst = 1'b0;

        // Basic frame: four outputs, origin of tile (1,2) pinned
        new_frame();
        add_tile(16'd0, 16'd0, 16'd3);
        add_tile(16'd1, 16'd2, 16'd1);
        drive_frame();
        finish_frame("basic", 0, 4);
        if (cap_x.size() == 4) begin
            chk("basic_x", {cap_x[0], cap_x[1], cap_x[2], cap_x[3]}, {32'h0, 32'h0, 32'h0, 32'h0010_0000});
            chk("basic_y3", cap_y[3], 32'h0020_0000);
            chk("basic_eot", {cap_eot[0], cap_eot[1], cap_eot[2], cap_eot[3]}, 4'b0011);
        end

        // Empty tiles around one tile whose origin overflows 32 bits
        new_frame();
        add_tile(16'd3, 16'd4, 16'd0);
        add_tile(16'hFFFF, 16'h8001, 16'd2);
        add_tile(16'd7, 16'd8, 16'd0);
        drive_frame();
        finish_frame("empty", 2, 2);
        if (cap_x.size() == 2) begin
            chk("empty_origin_trunc", {cap_x[0], cap_y[0]}, {32'hFFF0_0000, 32'h0010_0000});
            chk("empty_eot", {cap_eot[0], cap_eot[1]}, 2'b01);
        end

        // num_tiles = 0: done within two cycles, no tile_ready
        new_frame();
        drive_frame();
        finish_frame("zero", 0, 0);
        chk("zero_no_tile_ready", tr_cnt, 0);
        chk("zero_latency_ok", 1'(done_t - start_t <= 20), 1'b1);

        // Start while busy must be ignored
        new_frame();
        rdy_mode = 1;
        add_tile(16'd5, 16'd6, 16'd3);
        add_tile(16'd9, 16'd2, 16'd3);
        fork
            drive_frame();
            begin
                repeat (4) @(negedge clk);
                start = 1'b1; num_tiles = 16'd9;
                @(negedge clk);
                start = 1'b0;
            end
        join
        finish_frame("busy_start", 0, 6);

        // Backpressure: five stalled cycles with a word waiting
        new_frame();
        rdy_mode = 2;
        add_tile(16'd2, 16'd3, 16'd3);
        fork
            drive_frame();
            begin
                cyc = 0;
                do begin @(negedge clk); #2; cyc++; end while (!out_valid && cyc < 100);
                for (int i = 0; i < 5; i++) begin
                    chk("bp_valid", out_valid, 1);
                    chk("bp_g_ready", g_ready, 0);
                    if (i < 4) begin @(negedge clk); #2; end
                end
                rdy_mode = 0;
            end
        join
        finish_frame("bp", 0, 3);
`ifdef COEFF_SCHED_STATS_EN
        chk("stat_stall", stat_stall, 5);
        chk("stat_issued", stat_issued, 3);
`endif

        interrupt_test("abort", 1'b0);
        interrupt_test("reset", 1'b1);

        // Random frames with random out_ready and g_valid gaps
        for (int f = 0; f < 8; f++) begin
            new_frame();
            rdy_mode = 1;
            n = $urandom_range(1, 4);
            zeros = 0; outs = 0;
            for (int t = 0; t < n; t++) begin
                add_tile(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 4)));
                if (ft_g[t] == 0) zeros++;
                outs += int'(ft_g[t]);
            end
            drive_frame();
            finish_frame("rand", zeros, outs);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/coeff_sched.md
COEFF_SCHED -- requirements
Module: coeff_sched

Interface
REQ-001 Parameter TILE_SIZE, default 16: tile edge in pixels; must be a power of two.
REQ-002 Parameter DATA_WIDTH, default 32: width of the signed fixed-point data words.
REQ-003 Parameter FRAC_BITS, default 16: number of fractional bits in the data words.
REQ-004 Parameter CNT_WIDTH, default 16: width of the tile and Gaussian counters.
REQ-005 Ports SHALL be as follows; clock and reset are listed first.
- clk  in  1  sole clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  frame-start pulse; honoured only in IDLE.
- num_tiles  in  CNT_WIDTH  number of tiles in the frame; sampled on start.
- abort  in  1  synchronous cancel of the frame.
- busy  out  1  high when the state is not IDLE.
- done  out  1  one-cycle pulse at frame completion.
- tile_valid / tile_ready  in / out  1 / 1  handshake for tile descriptors.
- tile_x, tile_y  in  CNT_WIDTH each  tile index.
- tile_gcount  in  CNT_WIDTH  number of Gaussians in the tile.
- tile_skip  out  1  one-cycle pulse when a tile with tile_gcount==0 is consumed.
- g_valid / g_ready  in / out  1 / 1  handshake for Gaussian parameters.
- g_a, g_b, g_c, g_mu_x, g_mu_y  in  DATA_WIDTH each  signed Gaussian parameters.
- out_valid / out_ready  out / in  1 / 1  handshake toward the coefficient calculator.
- out_a, out_b, out_c, out_mu_x, out_mu_y, out_x, out_y  out  DATA_WIDTH each  issued operands.
- out_end_of_tile  out  1  marks the last Gaussian of a tile.

Function
REQ-006 The controller SHALL use four states: IDLE, LOAD_TILE, ISSUE and DONE.
REQ-007 In IDLE, start SHALL latch num_tiles into tiles_left and move to LOAD_TILE; if num_tiles==0 it SHALL move to DONE instead.
REQ-008 In LOAD_TILE, tile_ready SHALL be 1; in every other state it SHALL be 0.
REQ-009 On a tile handshake, the block SHALL latch origin_x = tile_x*TILE_SIZE<<FRAC_BITS and origin_y = tile_y*TILE_SIZE<<FRAC_BITS, each truncated to DATA_WIDTH, and load gauss_left = tile_gcount.
REQ-010 On a tile handshake with tile_gcount==0, the block SHALL:
- pulse tile_skip;
- decrement tiles_left;
- go to DONE if tiles_left was 1, otherwise stay in LOAD_TILE.
REQ-011 On a tile handshake with tile_gcount>0, the block SHALL go to ISSUE.
REQ-012 In ISSUE, g_ready SHALL equal (!out_valid || out_ready); in every other state g_ready SHALL be 0.
REQ-013 On a Gaussian handshake, the output register SHALL load on the next edge, so out_valid rises 1 cycle after the handshake. The loaded values SHALL be:
- the g_* fields into the matching out_* fields;
- origin_x into out_x and origin_y into out_y;
- out_end_of_tile = (gauss_left==1).
REQ-014 The same Gaussian handshake SHALL decrement gauss_left. On the last Gaussian it SHALL also decrement tiles_left and go to LOAD_TILE, or to DONE if tiles_left was 1.
REQ-015 The output register SHALL hold all out_* values stable while out_valid && !out_ready.
REQ-016 Back-to-back operation SHALL give one Gaussian per cycle while out_ready stays high.
REQ-017 out_valid SHALL clear on an output handshake unless a new Gaussian loads in the same cycle.
REQ-018 DONE SHALL wait until out_valid==0, or until an output handshake occurs that cycle. It SHALL then pulse done for exactly one cycle and enter IDLE on the following edge.
REQ-019 start asserted outside IDLE SHALL be ignored.
REQ-020 abort SHALL take priority over start and every handshake. It SHALL force IDLE and clear out_valid and the counters on the next edge, and done SHALL not pulse.
REQ-021 Counters SHALL never wrap: a tile handshake SHALL never occur with tiles_left==0, and a Gaussian handshake SHALL never occur with gauss_left==0.

Reset
REQ-022 While rst is high at a clock edge, the block SHALL set:
- state = IDLE;
- out_valid, done, tile_skip, busy = 0;
- out_end_of_tile = 0 and all out_* data = 0;
- tiles_left, gauss_left, origin_x, origin_y = 0.
REQ-023 Reset asserted mid-frame SHALL discard the frame with no done pulse, and the first cycle after reset SHALL accept start.

Configuration
REQ-024 With COEFF_SCHED_STATS_EN defined, the block SHALL add two CNT_WIDTH outputs, both cleared by reset and by start accepted in IDLE, and both saturating at their maximum value:
- stat_issued: counts output handshakes;
- stat_stall: counts cycles with out_valid && !out_ready.
REQ-025 With COEFF_SCHED_STATS_EN undefined, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-026 Basic frame: num_tiles=2, tiles (0,0,3) and (1,2,1), out_ready=1 -> four outputs.
- out_x = 0, 0, 0, then 0x00100000; out_y = 0x00200000 on the fourth;
- out_end_of_tile = 0,0,1,1;
- done pulses once.
REQ-027 Empty tiles: num_tiles=3 with gcounts 0,2,0 -> tile_skip pulses twice, two outputs (last has out_end_of_tile=1), done pulses once.
REQ-028 Backpressure: out_ready held 0 for 5 cycles with out_valid=1 -> out_* stable and g_ready=0; with stats enabled, stat_stall=5.
REQ-029 Boundary cases:
- num_tiles=0 -> done pulses within 2 cycles of start, no tile_ready;
- start while busy -> ignored.
REQ-030 Interruptions: abort, or rst, asserted while out_valid=1 in ISSUE -> next cycle IDLE, out_valid=0, no done; a new start is accepted on the following cycle.
